// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_NOP  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_MOD  = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SHL1 = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIN
    } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Start/busy/done handshake and result bus between control FSM (master) and ALU (slave).
interface alu_multicycle_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic                start;
    logic [ALU_OP_W-1:0] alu_op;
    logic [WIDTH-1:0]    in1;
    logic [WIDTH-1:0]    in2;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    alu_out;
    logic                z;
    logic                c;
    logic                dz;

    modport master (
        output start, alu_op, in1, in2,
        input  busy, done, alu_out, z, c, dz
    );

    modport slave (
        input  start, alu_op, in1, in2,
        output busy, done, alu_out, z, c, dz
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator ({hi, lo}) and one step counter.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             op_is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mul_q, mul_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     trial;

    always_comb begin
        acc_d   = acc_q;
        b_d     = b_q;
        mul_d   = mul_q;
        cnt_d   = cnt_q;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder shifted left with the next dividend bit; bit WIDTH of trial is the borrow.
        div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = div_sh - {1'b0, b_q};
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, a};
            b_d   = b;
            mul_d = op_is_mul;
            cnt_d = CNT_W'(WIDTH);
        end else if (step) begin
            if (mul_q) begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        b_q   <= b_d;
        mul_q <= mul_d;
    end

    assign last       = (cnt_q == CNT_W'(1));
    assign product_lo = acc_q[WIDTH-1:0];
    assign product_hi = acc_q[2*WIDTH-1:WIDTH];
    assign quotient   = acc_q[WIDTH-1:0];
    assign remainder  = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle unsigned ALU: control FSM, single-cycle datapath, result mux and flags.
// Results and flags are registered on the edge that leaves FIN, together with done.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    alu_multicycle_if.slave bus
);

    state_t              state_q, state_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [WIDTH-1:0]    in1_q, in1_d;
    logic [WIDTH-1:0]    in2_q, in2_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    alu_out_q, alu_out_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                dz_q, dz_d;

    logic             md_load, md_step, md_last, md_is_mul;
    logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res;
    logic             res_c, res_dz, res_wr;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (md_load),
        .op_is_mul  (md_is_mul),
        .a          (bus.in1),
        .b          (bus.in2),
        .step       (md_step),
        .product_lo (prod_lo),
        .product_hi (prod_hi),
        .quotient   (quot),
        .remainder  (rem),
        .last       (md_last)
    );

    assign md_is_mul = (bus.alu_op == ALU_MUL);

    always_comb begin
        res    = alu_out_q;
        res_c  = 1'b0;
        res_dz = 1'b0;
        res_wr = 1'b1;
        sum    = {1'b0, in1_q} + {1'b0, in2_q};
        diff   = {1'b0, in1_q} - {1'b0, in2_q};
        case (op_q)
            ALU_ADD:  begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
            ALU_XOR:  res = in1_q ^ in2_q;
            ALU_MUL:  begin res = prod_lo; res_c = |prod_hi; end
            ALU_DIV:  begin
                if (in2_q == '0) begin res = '1; res_dz = 1'b1; end
                else             res = quot;
            end
            ALU_MOD:  begin
                if (in2_q == '0) begin res = in1_q; res_dz = 1'b1; end
                else             res = rem;
            end
            ALU_SHL1: begin res = {in1_q[WIDTH-2:0], 1'b0}; res_c = in1_q[WIDTH-1]; end
            ALU_SUB:  begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
            default:  res_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        done_d    = 1'b0;
        alu_out_d = alu_out_q;
        z_d       = z_q;
        c_d       = c_q;
        dz_d      = dz_q;
        md_load   = 1'b0;
        md_step   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.alu_op;
                    in1_d = bus.in1;
                    in2_d = bus.in2;
                    // Divide by zero skips iteration; the result mux supplies the fixed answer.
                    if (bus.alu_op == ALU_MUL ||
                        ((bus.alu_op == ALU_DIV || bus.alu_op == ALU_MOD) && bus.in2 != '0)) begin
                        md_load = 1'b1;
                        state_d = S_ITER;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ITER: begin
                md_step = 1'b1;
                if (md_last) state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (res_wr) begin
                    alu_out_d = res;
                    z_d       = (res == '0);
                    c_d       = res_c;
                    dz_d      = res_dz;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            alu_out_q <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            alu_out_q <= alu_out_d;
            z_q       <= z_d;
            c_q       <= c_d;
            dz_q      <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        in1_q <= in1_d;
        in2_q <= in2_d;
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.alu_out = alu_out_q;
    assign bus.z       = z_q;
    assign bus.c       = c_q;
    assign bus.dz      = dz_q;

endmodule
